// File: rtl/incident_frame_tx.sv
// incident_frame_tx: queues timestamped incident events and serialises each
// one as a 13-byte sync/seq/payload/checksum frame to a ready/valid byte sink.
module incident_frame_tx #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] SYNC0 = 8'hAA,
  parameter logic [7:0] SYNC1 = 8'h55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       incident_inform,
  input  logic [7:0] incident_b0,
  input  logic [7:0] incident_b1,
  input  logic [7:0] incident_b2,
  input  logic [7:0] incident_b3,
  input  logic [7:0] ds_MsecondsL,
  input  logic [7:0] ds_MsecondsH,
  input  logic [7:0] ds_Seconds,
  input  logic [7:0] ds_Minutes,
  input  logic [7:0] ds_Hour,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t      state;
  logic [71:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [71:0] shadow;
  logic [3:0]  idx;
  logic [3:0]  nidx;
  logic [3:0]  pidx;
  logic [7:0]  seq;
  logic [7:0]  chk;
  logic [7:0]  next_byte;
  logic        full, pop, push_ok, drop;

  // A full FIFO still takes a push when the head is leaving in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = (state == LOAD);
  assign push_ok = incident_inform & (~full | pop);
  assign drop    = incident_inform & full & ~pop;
  assign busy    = (state != IDLE) | (count != '0);
  assign nidx    = idx + 4'd1;
  assign pidx    = nidx - 4'd3;

  // Entry layout: byte k is the k-th payload byte of the frame (b0 first).
  always_ff @(posedge clk)
    if (push_ok)
      mem[wr_ptr] <= {ds_Hour, ds_Minutes, ds_Seconds, ds_MsecondsH, ds_MsecondsL,
                      incident_b3, incident_b2, incident_b1, incident_b0};

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end

  // Drop reporting: one-cycle pulse per lost event plus saturating tally.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      overflow <= drop;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end

  // Checksum covers SEQ plus the nine payload bytes of the frame in flight.
  always_comb begin
    chk = seq;
    for (int k = 0; k < 9; k++) chk = chk + shadow[8*k +: 8];
  end

  // Byte that follows the one currently presented.
  always_comb begin
    next_byte = 8'h00;
    case (nidx)
      4'd0:    next_byte = SYNC0;
      4'd1:    next_byte = SYNC1;
      4'd2:    next_byte = seq;
      4'd12:   next_byte = chk;
      default: if (nidx >= 4'd3 && nidx <= 4'd11) next_byte = shadow[{pidx, 3'b000} +: 8];
    endcase
  end

  // Frame sequencer: pop into the shadow, then walk 13 bytes under handshake.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      idx      <= 4'd0;
      seq      <= 8'h00;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: if (count != '0) state <= LOAD;
        LOAD: begin
          shadow   <= mem[rd_ptr];
          idx      <= 4'd0;
          tx_valid <= 1'b1;
          tx_data  <= SYNC0;
          state    <= SEND;
        end
        SEND: if (tx_ready) begin
          if (idx == 4'd12) begin
            tx_valid <= 1'b0;
            seq      <= seq + 8'h01;
            state    <= IDLE;
          end else begin
            idx     <= nidx;
            tx_data <= next_byte;
          end
        end
        default: state <= IDLE;
      endcase
    end

endmodule

// File: tb/tb_incident_frame_tx.sv
// Bench for incident_frame_tx: randomized events, frame-level reference model.
module tb_incident_frame_tx;

  typedef logic [7:0] ev_t [9];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       incident_inform = 1'b0;
  logic [7:0] b0 = 0, b1 = 0, b2 = 0, b3 = 0, msl = 0, msh = 0, sec = 0, mn = 0, hr = 0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_cnt;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int unsigned mseq = 0;

  incident_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .incident_inform(incident_inform),
    .incident_b0(b0), .incident_b1(b1), .incident_b2(b2), .incident_b3(b3),
    .ds_MsecondsL(msl), .ds_MsecondsH(msh), .ds_Seconds(sec), .ds_Minutes(mn), .ds_Hour(hr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference: frame = AA 55 SEQ payload[9] CHK, CHK = (SEQ + sum payload) mod 256.
  task automatic model_push(input ev_t e);
    int s;
    s = mseq;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'(mseq));
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(e[k]);
      s = s + e[k];
    end
    exp_q.push_back(8'(s % 256));
    mseq = (mseq + 1) % 256;
  endtask

  task automatic rand_ev(output ev_t e);
    for (int k = 0; k < 9; k++) e[k] = 8'($urandom);
  endtask

  task automatic set_event(input ev_t e);
    incident_inform = 1'b1;
    b0 = e[0]; b1 = e[1]; b2 = e[2]; b3 = e[3];
    msl = e[4]; msh = e[5]; sec = e[6]; mn = e[7]; hr = e[8];
  endtask

  // Called at a negedge; records bytes accepted at following posedges.
  task automatic collect(input int n, input bit rnd, output bit to);
    int target, cyc;
    target = got.size() + n;
    cyc = 0;
    to = 1'b0;
    while (1) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (got.size() >= target) break;
      cyc++;
      if (cyc > 3000) begin to = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    incident_inform = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mseq = 0;
    exp_q.delete();
    got.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 5;
    if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else passed++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
    if (drop_cnt !== 8'h00) $display("FAIL reset_drop_cnt got %h want 00", drop_cnt); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    ev_t e;
    bit to;
    e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h00, 8'h20, 8'h30, 8'h12};
    tx_ready = 1'b1;
    set_event(e);
    model_push(e);
    @(negedge clk);
    incident_inform = 1'b0;
    total += 2;
    if (tx_valid !== 1'b0) $display("FAIL lat_n got valid %b want 0", tx_valid); else passed++;
    if (busy !== 1'b1) $display("FAIL lat_busy got %b want 1", busy); else passed++;
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) $display("FAIL lat_n1 got valid %b want 0", tx_valid); else passed++;
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hAA)
      $display("FAIL lat_n2 got valid %b data %h want 1 AA", tx_valid, tx_data);
    else passed++;
    collect(13, 1'b0, to);
    total++;
    if (to) begin $display("FAIL single_timeout got %0d bytes want 13", got.size()); return; end
    else passed++;
    for (int i = 0; i < 13; i++) begin
      total++;
      if (got[i] !== exp_q[i]) $display("FAIL single_byte%0d got %h want %h", i, got[i], exp_q[i]);
      else passed++;
    end
    got.delete(); exp_q.delete();
    @(negedge clk);
    rand_ev(e);
    set_event(e);
    model_push(e);
    @(negedge clk);
    incident_inform = 1'b0;
    collect(13, 1'b0, to);
    total++;
    if (to) begin $display("FAIL single2_timeout got %0d bytes want 13", got.size()); return; end
    else passed++;
    total++;
    if (got[2] !== 8'h01) $display("FAIL single2_seq got %h want 01", got[2]); else passed++;
    for (int i = 0; i < 13; i++) begin
      total++;
      if (got[i] !== exp_q[i]) $display("FAIL single2_byte%0d got %h want %h", i, got[i], exp_q[i]);
      else passed++;
    end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    ev_t e;
    bit pv, pr, r, inj;
    logic [7:0] pd;
    int cyc;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rand_ev(e); set_event(e); model_push(e);
      @(negedge clk);
    end
    incident_inform = 1'b0;
    pv = 0; pr = 0; pd = 0; inj = 0; cyc = 0;
    while (got.size() < 39 && cyc < 3000) begin
      incident_inform = 1'b0;
      if (pv && !pr) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== pd)
          $display("FAIL stall_hold got valid %b data %h want 1 %h", tx_valid, tx_data, pd);
        else passed++;
      end
      // Third event lands while a frame is on the wire.
      if (!inj && got.size() >= 5) begin
        rand_ev(e); set_event(e); model_push(e);
        inj = 1;
      end
      r = 1'($urandom_range(0, 1));
      tx_ready = r;
      if (tx_valid && r) got.push_back(tx_data);
      pv = tx_valid; pr = r; pd = tx_data;
      cyc++;
      @(negedge clk);
    end
    incident_inform = 1'b0;
    total++;
    if (got.size() != 39) begin $display("FAIL stall_count got %0d bytes want 39", got.size()); return; end
    else passed++;
    for (int i = 0; i < 39; i++) begin
      total++;
      if (got[i] !== exp_q[i]) $display("FAIL stall_byte%0d got %h want %h", i, got[i], exp_q[i]);
      else passed++;
    end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    ev_t e;
    bit to;
    logic exp_ov;
    apply_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_ev(e); set_event(e);
      if (i < 5) model_push(e);
      @(negedge clk);
      exp_ov = (i == 5);
      total++;
      if (overflow !== exp_ov) $display("FAIL ovf_pulse%0d got %b want %b", i, overflow, exp_ov);
      else passed++;
    end
    incident_inform = 1'b0;
    @(negedge clk);
    total += 2;
    if (overflow !== 1'b0) $display("FAIL ovf_end got %b want 0", overflow); else passed++;
    if (drop_cnt !== 8'd1) $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); else passed++;
    tx_ready = 1'b1;
    collect(13, 1'b0, to);
    total++;
    if (to) begin $display("FAIL ovf_timeout got %0d want 13", got.size()); return; end else passed++;
    @(negedge clk);
    @(negedge clk);
    // The sequencer is popping at the coming edge while the FIFO is full.
    rand_ev(e); set_event(e); model_push(e);
    @(negedge clk);
    incident_inform = 1'b0;
    total += 2;
    if (overflow !== 1'b0) $display("FAIL popcycle_ovf got %b want 0", overflow); else passed++;
    if (drop_cnt !== 8'd1) $display("FAIL popcycle_drop_cnt got %0d want 1", drop_cnt); else passed++;
    collect(65, 1'b0, to);
    total++;
    if (to) begin $display("FAIL ovf_drain_timeout got %0d want 78", got.size()); return; end else passed++;
    for (int i = 0; i < 78; i++) begin
      total++;
      if (got[i] !== exp_q[i]) $display("FAIL ovf_byte%0d got %h want %h", i, got[i], exp_q[i]);
      else passed++;
    end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    ev_t e;
    bit to;
    int resid;
    apply_reset();
    tx_ready = 1'b1;
    rand_ev(e); set_event(e); model_push(e);
    @(negedge clk);
    incident_inform = 1'b0;
    collect(5, 1'b0, to);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (tx_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", tx_valid); else passed++;
    if (tx_data !== 8'h00) $display("FAIL midrst_data got %h want 00", tx_data); else passed++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    resid = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid) resid++;
    end
    total += 2;
    if (resid != 0) $display("FAIL midrst_residual got %0d valid cycles want 0", resid); else passed++;
    if (busy !== 1'b0) $display("FAIL midrst_busy_after got %b want 0", busy); else passed++;
    // Strobe on the very first edge after release.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    mseq = 0; exp_q.delete(); got.delete();
    rand_ev(e); set_event(e); model_push(e);
    rst_n = 1'b1;
    @(negedge clk);
    incident_inform = 1'b0;
    collect(13, 1'b0, to);
    total++;
    if (to) begin $display("FAIL firstedge_timeout got %0d want 13", got.size()); return; end else passed++;
    for (int i = 0; i < 13; i++) begin
      total++;
      if (got[i] !== exp_q[i]) $display("FAIL firstedge_byte%0d got %h want %h", i, got[i], exp_q[i]);
      else passed++;
    end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_saturate();
    ev_t e;
    int ovc;
    apply_reset();
    tx_ready = 1'b0;
    ovc = 0;
    for (int i = 0; i < 305; i++) begin
      rand_ev(e); set_event(e);
      @(negedge clk);
      if (overflow) ovc++;
    end
    incident_inform = 1'b0;
    @(negedge clk);
    total += 2;
    if (drop_cnt !== 8'd255) $display("FAIL sat_drop_cnt got %0d want 255", drop_cnt); else passed++;
    if (ovc != 300) $display("FAIL sat_ovf_pulses got %0d want 300", ovc); else passed++;
  endtask

  task automatic test_seq_wrap();
    ev_t e;
    bit to, bad;
    apply_reset();
    tx_ready = 1'b1;
    for (int f = 0; f < 257; f++) begin
      rand_ev(e); set_event(e); model_push(e);
      @(negedge clk);
      incident_inform = 1'b0;
      collect(13, 1'b0, to);
      if (to) begin total++; $display("FAIL wrap_timeout frame %0d", f); return; end
      bad = 0;
      for (int i = 0; i < 13; i++) if (got[i] !== exp_q[i]) bad = 1;
      total++;
      if (bad) $display("FAIL wrap_frame%0d got seq %h chk %h want seq %h chk %h",
                        f, got[2], got[12], exp_q[2], exp_q[12]);
      else passed++;
      if (f == 256) begin
        total++;
        if (got[2] !== 8'h00) $display("FAIL wrap_seq got %h want 00", got[2]); else passed++;
      end
      got.delete(); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_reset_midframe();
    test_saturate();
    test_seq_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
